multicycle_ctrl_fsm: RTL and testbench

//  Moore FSM sequencing the multicycle MIPS datapath (shared memory, IR, ALU, regfile, PC).

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 63 ++++++
 rtl/multicycle_ctrl_fsm_decode.sv | 74 +++++++
 rtl/multicycle_ctrl_fsm.sv | 113 +++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control FSM.
// Contents: opcodes, ALU operation / operand-select / PC-source codes,
// the 4-bit state encoding and the packed control vector driven by the
// decoder into the datapath.
`timescale 1ns/1ps
package multicycle_ctrl_fsm_pkg;

    // Opcodes from IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALU operation codes
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B-operand selects
    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_decode.sv
// mc_ctrl_decode: combinational Moore decode of the controller state into
// the datapath control vector. mem_ready only gates the strobes that must
// not fire until a memory access actually completes.
// Ports:
//   i_state     current controller state
//   i_mem_ready memory handshake (already forced high when unused)
//   o_ctrl      full control vector, including instr_done
`timescale 1ns/1ps
module mc_ctrl_decode
    import multicycle_ctrl_fsm_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_FOUR;
                // PC+4 and IR are captured only when the fetch returns
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // speculative branch target computed into ALUOut
                o_ctrl.alu_src_b = ALUSRCB_IMMSH;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_IMM;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.i_or_d     = 1'b1;
                // store retires only on the cycle the write is accepted
                o_ctrl.instr_done = i_mem_ready;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALU_OP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.instr_done    = 1'b1;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore controller for the multicycle MIPS datapath.
// Holds the state register, next-state logic, retired-instruction counter
// and the sticky illegal-opcode flag; control outputs come from
// mc_ctrl_decode.
// Ports:
//   clk, reset (async, active-low), run (permits a new fetch),
//   instr_op (IR[31:26]), mem_ready (memory handshake)
//   datapath controls: pc_write, pc_write_cond, pc_source, i_or_d,
//   mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
//   alu_src_a, alu_src_b, alu_op
//   status: instr_done, illegal_op, instr_count
`timescale 1ns/1ps
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       instr_op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_illegal;
    logic             w_mem_ready;
    state_t           w_after_final;
    ctrl_t            w_ctrl;

    assign w_mem_ready   = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign w_after_final = run ? S_FETCH : S_IDLE;

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (w_mem_ready),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            // instr_done is only ever asserted in a retiring final state
            if (w_ctrl.instr_done) begin
                r_count <= r_count + CNT_W'(1);
            end
            case (r_state)
                S_IDLE:     if (run) r_state <= S_FETCH;
                S_FETCH:    if (w_mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (instr_op)
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDI_EX;
                        default: begin
                            r_state   <= S_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: r_state <= (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (w_mem_ready) r_state <= S_MEM_WB;
                S_MEM_WR:   if (w_mem_ready) r_state <= w_after_final;
                S_EXEC:     r_state <= S_R_WB;
                S_ADDI_EX:  r_state <= S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB: r_state <= w_after_final;
                // absorbing: only reset leaves the trap
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign pc_source     = w_ctrl.pc_source;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign instr_done    = w_ctrl.instr_done;
    assign illegal_op    = r_illegal;
    assign instr_count   = r_count;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. The reference model tracks
// each instruction as a string of step letters (F fetch, D decode, then an
// opcode-specific tail) and derives the expected control vector from the
// current letter; memory letters (F, R, S) repeat while mem_ready is low.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    localparam int CNT_W = 4;
    // bit positions in the 17-bit observed control vector
    localparam int PW = 16, PWC = 15, PS = 13, IOD = 12, MRD = 11, MWR = 10, IRW = 9;
    localparam int MTR = 8, RDST = 7, RW = 6, ASA = 5, ASB = 3, AOP = 1, DONE = 0;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic [5:0]       instr_op = 6'h00;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0]       pc_source, alu_src_b, alu_op;
    logic [CNT_W-1:0] instr_count;
    logic [16:0]      dut_vec;

    int errors = 0;
    int checks = 0;

    // model state
    bit          m_active = 0;
    bit          m_trap   = 0;
    byte         m_seq[$];
    int          m_pos    = 0;
    int unsigned m_count  = 0;

    multicycle_ctrl_fsm #(.USE_MEM_READY(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_op(instr_op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    assign dut_vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                      alu_op, instr_done};

    always #5 clk = ~clk;

    function automatic logic [16:0] exp_ctrl(input logic mr);
        logic [16:0] v;
        byte l;
        v = '0;
        if (m_trap || !m_active) return v;
        l = m_seq[m_pos];
        case (l)
            "F": begin v[MRD] = 1; v[ASB+:2] = 2'b01; v[PW] = mr; v[IRW] = mr; end
            "D": v[ASB+:2] = 2'b11;
            "A", "I": begin v[ASA] = 1; v[ASB+:2] = 2'b10; end
            "R": begin v[MRD] = 1; v[IOD] = 1; end
            "W": begin v[RW] = 1; v[MTR] = 1; v[DONE] = 1; end
            "S": begin v[MWR] = 1; v[IOD] = 1; v[DONE] = mr; end
            "E": begin v[ASA] = 1; v[AOP+:2] = 2'b10; end
            "r": begin v[RW] = 1; v[RDST] = 1; v[DONE] = 1; end
            "B": begin v[ASA] = 1; v[AOP+:2] = 2'b01; v[PWC] = 1; v[PS+:2] = 2'b01; v[DONE] = 1; end
            "i": begin v[RW] = 1; v[DONE] = 1; end
            default: v = '1;
        endcase
        return v;
    endfunction

    task automatic model_start();
        m_seq.delete();
        m_seq.push_back("F");
        m_seq.push_back("D");
        m_pos = 0;
        m_active = 1;
    endtask

    task automatic model_advance(input logic r, input logic mr, input logic [5:0] op);
        byte l;
        if (m_trap) return;
        if (!m_active) begin
            if (r) model_start();
            return;
        end
        l = m_seq[m_pos];
        if ((l == "F" || l == "R" || l == "S") && !mr) return;
        if (l == "D") begin
            case (op)
                6'h00: begin m_seq.push_back("E"); m_seq.push_back("r"); end
                6'h23: begin m_seq.push_back("A"); m_seq.push_back("R"); m_seq.push_back("W"); end
                6'h2B: begin m_seq.push_back("A"); m_seq.push_back("S"); end
                6'h04: m_seq.push_back("B");
                6'h08: begin m_seq.push_back("I"); m_seq.push_back("i"); end
                default: begin m_trap = 1; m_active = 0; return; end
            endcase
            m_pos++;
        end else if (m_pos == m_seq.size() - 1) begin
            m_count++;
            if (r) model_start();
            else m_active = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_trap = 0; m_count = 0; m_pos = 0;
        m_seq.delete();
    endtask

    task automatic check_model(input string name, input logic mr);
        logic [16:0] ev;
        logic [CNT_W-1:0] ec;
        ev = exp_ctrl(mr);
        ec = CNT_W'(m_count);
        checks++;
        if (dut_vec !== ev) begin
            errors++;
            $display("FAIL %s ctrl t=%0t got=%05h exp=%05h", name, $time, dut_vec, ev);
        end
        checks++;
        if (instr_count !== ec) begin
            errors++;
            $display("FAIL %s count t=%0t got=%0d exp=%0d", name, $time, instr_count, ec);
        end
        checks++;
        if (illegal_op !== m_trap) begin
            errors++;
            $display("FAIL %s illegal t=%0t got=%b exp=%b", name, $time, illegal_op, m_trap);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic step(input logic r, input logic mr, input logic [5:0] op);
        @(negedge clk);
        run = r; mem_ready = mr; instr_op = op;
        #1;
        check_model("cycle", mr);
        model_advance(r, mr, op);
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_model("reset", 1'b1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Issues one instruction from IDLE with run dropped after the start;
    // holds mem_ready low for rd_waits cycles of the load-read step.
    task automatic run_instr(input logic [5:0] op, input int rd_waits,
                             output int done_cyc, output logic [16:0] snap);
        int waits;
        logic mr;
        waits = rd_waits;
        done_cyc = -1;
        snap = '0;
        step(1'b1, 1'b1, op);
        for (int n = 1; n <= 30; n++) begin
            mr = 1'b1;
            if (m_active && m_seq[m_pos] == "R" && waits > 0) begin
                mr = 1'b0;
                waits--;
            end
            step(1'b0, mr, op);
            if (instr_done === 1'b1) begin
                done_cyc = n;
                snap = dut_vec;
                break;
            end
        end
        $display("instr op=%02h waits=%0d done_cycle=%0d", op, rd_waits, done_cyc);
    endtask

    initial begin
        int dc;
        int dones;
        logic [16:0] snap;
        logic seen_mrd;
        logic [5:0] op;
        int trap_cyc;
        int k;

        // power-up reset
        @(negedge clk);
        @(negedge clk);
        #1;
        model_reset();
        check_model("por", 1'b1);
        lit("por_ctrl", 32'(dut_vec), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // R-type: done on cycle 4 with reg_dst/reg_write
        run_instr(6'h00, 0, dc, snap);
        lit("rtype_cycles", 32'(dc), 32'd4);
        lit("rtype_wb_vec", 32'(snap), 32'(17'b0_0_00_0_0_0_0_0_1_1_0_00_00_1));

        // lw with three wait cycles in the read step: done on cycle 8
        run_instr(6'h23, 3, dc, snap);
        lit("lw_cycles", 32'(dc), 32'd8);
        lit("lw_wb_vec", 32'(snap), 32'(17'b0_0_00_0_0_0_0_1_0_1_0_00_00_1));

        // beq: three cycles, branch controls in the final step
        run_instr(6'h04, 0, dc, snap);
        lit("beq_cycles", 32'(dc), 32'd3);
        lit("beq_vec", 32'(snap), 32'(17'b0_1_01_0_0_0_0_0_0_0_1_00_01_1));

        // sw then addi back to back; run drops during addi
        dones = 0;
        step(1'b1, 1'b1, 6'h2B);
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 1'b1, 6'h2B);
            if (instr_done === 1'b1) dones++;
        end
        step(1'b1, 1'b1, 6'h08);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 6'h08);
            if (instr_done === 1'b1) dones++;
        end
        step(1'b0, 1'b1, 6'h08);
        lit("sw_addi_dones", 32'(dones), 32'd2);
        lit("sw_addi_count", 32'(instr_count), 32'd5);
        lit("sw_addi_idle", 32'(dut_vec), 32'h0);

        // reset asserted while the load waits in its read step
        step(1'b1, 1'b1, 6'h23);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 6'h23);
        step(1'b0, 1'b0, 6'h23);
        step(1'b0, 1'b0, 6'h23);
        do_reset();
        lit("midrd_rst_ctrl", 32'(dut_vec), 32'h0);
        lit("midrd_rst_count", 32'(instr_count), 32'd0);
        step(1'b1, 1'b1, 6'h00);
        step(1'b0, 1'b1, 6'h00);
        lit("restart_fetch_rd", 32'(mem_read), 32'd1);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 6'h00);

        // 4-bit counter wraps 15 -> 0
        do_reset();
        for (int n = 0; n < 15; n++) run_instr(6'h04, 0, dc, snap);
        step(1'b0, 1'b1, 6'h04);
        lit("count_15", 32'(instr_count), 32'd15);
        run_instr(6'h04, 0, dc, snap);
        step(1'b0, 1'b1, 6'h04);
        lit("count_wrap", 32'(instr_count), 32'd0);

        // illegal opcode traps; sticky, no further memory reads
        run_instr(6'h3F, 0, dc, snap);
        lit("trap_no_done", 32'(dc), 32'hFFFF_FFFF);
        seen_mrd = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 6'h00);
            if (mem_read !== 1'b0) seen_mrd = 1'b1;
        end
        lit("trap_illegal", 32'(illegal_op), 32'd1);
        lit("trap_no_mem_read", 32'(seen_mrd), 32'd0);
        lit("trap_count", 32'(instr_count), 32'd0);
        do_reset();

        // randomized traffic against the model
        op = 6'h00;
        trap_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_trap && trap_cyc > 3) begin
                do_reset();
                trap_cyc = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                do_reset();
                trap_cyc = 0;
            end else begin
                if (m_trap) trap_cyc++;
                if (!m_active || m_seq[m_pos] == "F") begin
                    k = $urandom_range(0, 20);
                    if (k < 4)       op = 6'h00;
                    else if (k < 8)  op = 6'h23;
                    else if (k < 12) op = 6'h2B;
                    else if (k < 16) op = 6'h04;
                    else if (k < 20) op = 6'h08;
                    else             op = 6'($urandom_range(0, 63));
                end
                step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, op);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
